// File: rtl/decode_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pipe_pkg
//  Description : Decode-stage control word layout, bubble kill mask and
//                pack/unpack helpers shared by the decode pipeline register.
//  Revision    : 1.0 - initial parametrised elastic version
// ============================================================================
package decode_pipe_pkg;

    // Total width of the packed decode control word.
    localparam int DEC_CTRL_W = 20;

    // Field positions, MSB first: AR, BR, ALU, input, wren, writeAd, ADR_MUX,
    // write, PC_load, cond, op2.
    localparam int DEC_AR_LSB      = 19;
    localparam int DEC_AR_W        = 1;
    localparam int DEC_BR_LSB      = 18;
    localparam int DEC_BR_W        = 1;
    localparam int DEC_ALU_LSB     = 14;
    localparam int DEC_ALU_W       = 4;
    localparam int DEC_INPUT_LSB   = 13;
    localparam int DEC_INPUT_W     = 1;
    localparam int DEC_WREN_LSB    = 12;
    localparam int DEC_WREN_W      = 1;
    localparam int DEC_WRITEAD_LSB = 9;
    localparam int DEC_WRITEAD_W   = 3;
    localparam int DEC_ADRMUX_LSB  = 8;
    localparam int DEC_ADRMUX_W    = 1;
    localparam int DEC_WRITE_LSB   = 7;
    localparam int DEC_WRITE_W     = 1;
    localparam int DEC_PCLOAD_LSB  = 6;
    localparam int DEC_PCLOAD_W    = 1;
    localparam int DEC_COND_LSB    = 3;
    localparam int DEC_COND_W      = 3;
    localparam int DEC_OP2_LSB     = 0;
    localparam int DEC_OP2_W       = 3;

    // Bits with architectural side effects; these must read 0 on a bubble.
    localparam logic [DEC_CTRL_W-1:0] DEC_KILL_MASK =
        (DEC_CTRL_W'(1) << DEC_WREN_LSB)  |
        (DEC_CTRL_W'(1) << DEC_WRITE_LSB) |
        (DEC_CTRL_W'(1) << DEC_PCLOAD_LSB);

    typedef struct packed {
        logic       ar;
        logic       br;
        logic [3:0] alu;
        logic       inp;
        logic       wren;
        logic [2:0] write_ad;
        logic       adr_mux;
        logic       write;
        logic       pc_load;
        logic [2:0] cond;
        logic [2:0] op2;
    } dec_ctrl_t;

    function automatic logic [DEC_CTRL_W-1:0] dec_pack(input dec_ctrl_t c);
        return c;
    endfunction

    function automatic dec_ctrl_t dec_unpack(input logic [DEC_CTRL_W-1:0] w);
        return dec_ctrl_t'(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pipe_if
//  Description : Upstream/downstream handshake bundle of the decode pipeline
//                register, plus its occupancy status.
//  Revision    : 1.0 - initial version
// ============================================================================
interface decode_pipe_if
    import decode_pipe_pkg::*;
#(
    parameter int DATA_W = DEC_CTRL_W,
    parameter int OCC_W  = 2
);
    logic [DATA_W-1:0] data_IN;
    logic              valid_IN;
    logic              ready_OUT;
    logic [DATA_W-1:0] data_OUT;
    logic              valid_OUT;
    logic              ready_IN;
    logic [OCC_W-1:0]  occ_OUT;

    // Environment side: drives the word and downstream ready.
    modport master (
        output data_IN, valid_IN, ready_IN,
        input  ready_OUT, data_OUT, valid_OUT, occ_OUT
    );

    // Pipeline side.
    modport slave (
        input  data_IN, valid_IN, ready_IN,
        output ready_OUT, data_OUT, valid_OUT, occ_OUT
    );
endinterface
`default_nettype wire

// File: rtl/decode_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pipe_stage
//  Description : One elastic stage: main register plus a skid register so
//                that ready depends only on local registered state.
//  Revision    : 1.0 - initial version
// ============================================================================
module decode_pipe_stage
    import decode_pipe_pkg::*;
#(
    parameter int DATA_W = DEC_CTRL_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_flush,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic              i_valid,
    output logic                   o_ready,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_valid,
    input  wire logic              i_ready,
    output logic [1:0]             o_occ
);

    logic              r_mv;
    logic              r_sv;
    logic [DATA_W-1:0] r_md;
    logic [DATA_W-1:0] r_sd;
    logic              w_main_free;

    // Main slot can load when empty or when its word leaves this cycle.
    assign w_main_free = !r_mv || i_ready;

    // Main/skid update: reset, then flush, then refill or skid capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mv <= 1'b0;
            r_sv <= 1'b0;
            r_md <= '0;
            r_sd <= '0;
        end else if (i_flush) begin
            // Payloads are kept; only the valid bits are dropped.
            r_mv <= 1'b0;
            r_sv <= 1'b0;
        end else if (w_main_free) begin
            if (r_sv) begin
                // Skid is older than anything upstream, so it goes first.
                r_md <= r_sd;
                r_mv <= 1'b1;
                r_sv <= 1'b0;
            end else begin
                r_md <= i_data;
                r_mv <= i_valid;
            end
        end else if (i_valid && !r_sv) begin
            r_sd <= i_data;
            r_sv <= 1'b1;
        end
    end

    assign o_ready = !r_sv;
    assign o_valid = r_mv;
    assign o_data  = r_md;
    assign o_occ   = {1'b0, r_mv} + {1'b0, r_sv};

endmodule
`default_nettype wire

// File: rtl/decode_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pipe_reg
//  Description : DEPTH cascaded elastic stages carrying the decode control
//                word to execute, with flush, bubble masking of side-effect
//                bits and an occupancy count. DEPTH legal range is 1..8.
//  Revision    : 1.0 - initial parametrised elastic version
// ============================================================================
module decode_pipe_reg
    import decode_pipe_pkg::*;
#(
    parameter int                 DATA_W    = DEC_CTRL_W,
    parameter int                 DEPTH     = 1,
    parameter logic [DATA_W-1:0]  KILL_MASK = '0
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    input  wire logic     FLUSH_IN,
    decode_pipe_if.slave  bus
);

    localparam int c_OCC_W = $clog2(2*DEPTH+1);

    // Index k is the input of stage k; index DEPTH is the pipeline output.
    logic [DATA_W-1:0] w_data [DEPTH+1];
    logic [DEPTH:0]    w_valid;
    logic [DEPTH:0]    w_ready;
    logic [1:0]        w_stage_occ [DEPTH];
    logic [c_OCC_W-1:0] w_occ_sum;

    assign w_data[0]      = bus.data_IN;
    assign w_valid[0]     = bus.valid_IN;
    assign w_ready[DEPTH] = bus.ready_IN;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        decode_pipe_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk     (CLK),
            .rst     (RST),
            .i_flush (FLUSH_IN),
            .i_data  (w_data[k]),
            .i_valid (w_valid[k]),
            .o_ready (w_ready[k]),
            .o_data  (w_data[k+1]),
            .o_valid (w_valid[k+1]),
            .i_ready (w_ready[k+1]),
            .o_occ   (w_stage_occ[k])
        );
    end

    // Occupancy: total of all main and skid valid bits across stages.
    always_comb begin
        w_occ_sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_occ_sum = w_occ_sum + c_OCC_W'(w_stage_occ[k]);
        end
    end

    // Held off during reset so nothing is handed over while state clears.
    assign bus.ready_OUT = !RST && w_ready[0];
    assign bus.valid_OUT = w_valid[DEPTH];
    assign bus.data_OUT  = w_valid[DEPTH] ? w_data[DEPTH]
                                          : (w_data[DEPTH] & ~KILL_MASK);
    assign bus.occ_OUT   = w_occ_sum;

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_pipe_reg
//  Description : Directed and random bench for decode_pipe_reg (DEPTH=2,
//                side-effect kill mask) with a queue scoreboard.
//  Revision    : 1.0 - initial version
// ============================================================================
module tb_decode_pipe_reg;
    import decode_pipe_pkg::*;

    localparam int DEPTH = 2;
    localparam int OCC_W = $clog2(2*DEPTH+1);

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    decode_pipe_if #(.DATA_W(DEC_CTRL_W), .OCC_W(OCC_W)) bus ();

    decode_pipe_reg #(
        .DATA_W    (DEC_CTRL_W),
        .DEPTH     (DEPTH),
        .KILL_MASK (DEC_KILL_MASK)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .FLUSH_IN (flush),
        .bus      (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [DEC_CTRL_W-1:0] exp_q [$];
    logic did_acc;
    logic did_fire;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample at negedge, score transfers, return 1 after posedge.
    task automatic cycle();
        logic [DEC_CTRL_W-1:0] w_exp;
        @(negedge clk);
        did_acc  = 1'b0;
        did_fire = 1'b0;
        if (!rst) chk("occ_vs_model", 32'(bus.occ_OUT), exp_q.size());
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (bus.valid_OUT && bus.ready_IN) begin
                did_fire = 1'b1;
                chk("fire_q_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    w_exp = exp_q.pop_front();
                    chk("fire_data", 32'(bus.data_OUT), 32'(w_exp));
                end
            end
            if (bus.valid_IN && bus.ready_OUT) begin
                did_acc = 1'b1;
                exp_q.push_back(bus.data_IN);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nf;
        int first_acc;
        int first_fire;
        int last_fire;
        dec_ctrl_t ctl;
        dec_ctrl_t ctl_o;
        logic [DEC_CTRL_W-1:0] kword;

        // ---------------- reset ----------------
        rst = 1'b1; flush = 1'b0;
        bus.valid_IN = 1'b1; bus.data_IN = 20'hABCDE; bus.ready_IN = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid_OUT", 32'(bus.valid_OUT), 0);
            chk("rst_data_OUT",  32'(bus.data_OUT),  0);
            chk("rst_occ_OUT",   32'(bus.occ_OUT),   0);
            chk("rst_ready_OUT", 32'(bus.ready_OUT), 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.valid_IN = 1'b0;
        @(negedge clk);
        chk("post_rst_ready_OUT", 32'(bus.ready_OUT), 1);
        @(posedge clk);
        #1;

        // ---------------- streaming ----------------
        bus.ready_IN = 1'b1;
        k = 1; nf = 0; first_acc = -1; first_fire = -1; last_fire = -1;
        for (int c = 0; c < 20; c++) begin
            bus.valid_IN = (k <= 10);
            bus.data_IN  = DEC_CTRL_W'(k * 4099);
            cycle();
            if (did_acc) begin
                if (k == 1) first_acc = c;
                k++;
            end
            if (did_fire) begin
                if (first_fire < 0) first_fire = c;
                last_fire = c;
                nf++;
            end
        end
        bus.valid_IN = 1'b0;
        chk("stream_latency",  first_fire - first_acc, 2);
        chk("stream_fires",    nf, 10);
        chk("stream_nobubble", last_fire - first_fire, 9);
        chk("stream_drained",  exp_q.size(), 0);

        // ---------------- backpressure ----------------
        bus.ready_IN = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            bus.valid_IN = 1'b1;
            bus.data_IN  = DEC_CTRL_W'(32'h5000 + k);
            cycle();
            if (did_acc) k++;
            if (k == 4) chk("bp_ready_low", 32'(bus.ready_OUT), 0);
        end
        bus.valid_IN = 1'b0;
        chk("bp_accepts", k, 4);
        chk("bp_occ", 32'(bus.occ_OUT), 4);
        bus.ready_IN = 1'b1;
        nf = 0;
        cycle();
        if (did_fire) nf++;
        chk("bp_ready_after1", 32'(bus.ready_OUT), 0);
        cycle();
        if (did_fire) nf++;
        chk("bp_ready_after2", 32'(bus.ready_OUT), 1);
        for (int c = 0; c < 10 && (exp_q.size() != 0 || bus.valid_OUT); c++) begin
            cycle();
            if (did_fire) nf++;
        end
        chk("bp_fires", nf, 4);
        chk("bp_drained", exp_q.size(), 0);

        // ---------------- random ----------------
        k = 0;
        bus.data_IN = DEC_CTRL_W'($urandom);
        for (int c = 0; c < 20000 && k < 1000; c++) begin
            bus.valid_IN = ($urandom_range(0, 99) < 70);
            bus.ready_IN = 1'($urandom_range(0, 1));
            cycle();
            if (did_acc) begin
                k++;
                bus.data_IN = DEC_CTRL_W'($urandom);
            end
        end
        bus.valid_IN = 1'b0;
        bus.ready_IN = 1'b1;
        for (int c = 0; c < 20 && (exp_q.size() != 0 || bus.valid_OUT); c++) cycle();
        chk("rand_accepts", k, 1000);
        chk("rand_drained", exp_q.size(), 0);

        // ---------------- flush ----------------
        bus.ready_IN = 1'b0;
        k = 0;
        for (int c = 0; c < 10 && k < 3; c++) begin
            bus.valid_IN = 1'b1;
            bus.data_IN  = DEC_CTRL_W'(32'h7000 + k);
            cycle();
            if (did_acc) k++;
        end
        chk("fl_pre_occ", 32'(bus.occ_OUT), 3);
        flush = 1'b1;
        bus.valid_IN = 1'b1;
        bus.data_IN  = 20'hF1F1F;
        cycle();
        flush = 1'b0;
        chk("fl_valid_OUT", 32'(bus.valid_OUT), 0);
        chk("fl_occ_OUT",   32'(bus.occ_OUT),   0);
        bus.ready_IN = 1'b1;
        bus.data_IN  = 20'h2468A;
        cycle();
        chk("fl_next_accept", 32'(did_acc), 1);
        bus.valid_IN = 1'b0;
        nf = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (did_fire) nf++;
        end
        chk("fl_fires", nf, 1);

        // ---------------- bubble masking ----------------
        ctl = '0;
        ctl.ar = 1'b1; ctl.alu = 4'hA; ctl.wren = 1'b1; ctl.write_ad = 3'd5;
        ctl.write = 1'b1; ctl.pc_load = 1'b1; ctl.cond = 3'd3; ctl.op2 = 3'd6;
        kword = dec_pack(ctl);
        bus.ready_IN = 1'b1;
        bus.valid_IN = 1'b1;
        bus.data_IN  = kword;
        cycle();
        chk("kill_accept", 32'(did_acc), 1);
        bus.valid_IN = 1'b0;
        nf = 0;
        repeat (4) begin
            cycle();
            if (did_fire) nf++;
        end
        chk("kill_fired_once", nf, 1);
        repeat (3) begin
            chk("kill_valid_OUT", 32'(bus.valid_OUT), 0);
            chk("kill_data_OUT",  32'(bus.data_OUT), 32'(kword & ~DEC_KILL_MASK));
            ctl_o = dec_unpack(bus.data_OUT);
            chk("kill_wren",    32'(ctl_o.wren),    0);
            chk("kill_pc_load", 32'(ctl_o.pc_load), 0);
            chk("kill_alu",     32'(ctl_o.alu),     32'h A);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
